ac_motor_pwm_bridge: RTL and testbench

AC_MOTOR_PWM_BRIDGE -- requirements
Module: ac_motor_pwm_bridge

---
 rtl/ac_motor_pwm_bridge_if.sv | 29 ++
 rtl/ac_motor_pwm_bridge.sv | 165 ++++++++++++++++
 tb/tb_ac_motor_pwm_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ac_motor_pwm_bridge_if.sv
// Command/carrier bundle for the PWM bridge.
// master drives carrier, references and control; slave receives them.
interface ac_motor_pwm_bridge_if #(
  parameter int CHANNELS = 3,
  parameter int SINE_W   = 12,
  parameter int TRI_W    = 17,
  parameter int DT_W     = 8
);
  logic                         enable;
  logic                         tri_peak;
  logic                         tri_valley;
  logic signed [TRI_W-1:0]      triangle;
  logic [CHANNELS*SINE_W-1:0]   sine;
  logic [DT_W-1:0]              deadtime;
  logic                         fault_in;
  logic                         fault_clear;

  modport master (
    output enable, tri_peak, tri_valley,
    output triangle, sine, deadtime,
    output fault_in, fault_clear
  );

  modport slave (
    input enable, tri_peak, tri_valley,
    input triangle, sine, deadtime,
    input fault_in, fault_clear
  );
endinterface

// File: rtl/ac_motor_pwm_bridge.sv
// Multi-leg sine/triangle PWM bridge with dead time and fault latch.
// In: clk, reset, enable, carrier+strobes, sine, deadtime, fault. Out: hi, lo, en, fault_latched.
module ac_motor_pwm_bridge #(
  parameter int CHANNELS    = 3,
  parameter int SINE_W      = 12,
  parameter int TRI_W       = 17,
  parameter int DT_W        = 8,
  parameter int UPDATE_MODE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       tri_peak,
  input  logic                       tri_valley,
  input  logic signed [TRI_W-1:0]    triangle,
  input  logic [CHANNELS*SINE_W-1:0] sine,
  input  logic [DT_W-1:0]            deadtime,
  input  logic                       fault_in,
  input  logic                       fault_clear,
  output logic [CHANNELS-1:0]        hi,
  output logic [CHANNELS-1:0]        lo,
  output logic [CHANNELS-1:0]        en,
  output logic                       fault_latched
);

  localparam int SH = TRI_W - SINE_W;

  typedef enum logic [2:0] {
    S_OFF, S_LO, S_DEAD_HI, S_HI, S_DEAD_LO
  } state_t;

  state_t                   state_q [CHANNELS];
  state_t                   state_d [CHANNELS];
  logic [DT_W-1:0]          cnt_q   [CHANNELS];
  logic [DT_W-1:0]          cnt_d   [CHANNELS];
  logic signed [SINE_W-1:0] shadow_q [CHANNELS];
  logic signed [SINE_W-1:0] shadow_d [CHANNELS];
  logic [CHANNELS-1:0]      dmd_q, dmd_d;
  logic                     fault_q, fault_d;
  logic                     en_q, en_d;
  logic                     load;
  logic                     kill;
  logic                     dt_zero;
  logic signed [TRI_W-1:0]  ref_ext;

  always_comb begin
    load = 1'b0;
    unique case (UPDATE_MODE)
      0:       load = 1'b1;
      1:       load = tri_valley;
      default: load = tri_peak | tri_valley;
    endcase
  end

  // fault_in beats fault_clear; the next latch value also gates the
  // bridge so a fault pulse kills the gates on the very next edge
  always_comb begin
    fault_d = fault_q;
    if (fault_in)
      fault_d = 1'b1;
    else if (fault_clear)
      fault_d = 1'b0;
  end

  assign kill    = ~enable | fault_d;
  assign en_d    = ~kill;
  assign dt_zero = (deadtime == '0);

  always_comb begin
    ref_ext = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      shadow_d[k] = shadow_q[k];
      if (load)
        shadow_d[k] = $signed(sine[k*SINE_W +: SINE_W]);
      ref_ext  = TRI_W'(shadow_q[k]);
      ref_ext  = ref_ext <<< SH;
      dmd_d[k] = (ref_ext > triangle);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
      en_q    <= 1'b0;
      dmd_q   <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k]  <= S_OFF;
        cnt_q[k]    <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      fault_q <= fault_d;
      en_q    <= en_d;
      dmd_q   <= dmd_d;
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k]  <= state_d[k];
        cnt_q[k]    <= cnt_d[k];
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      if (kill) begin
        state_d[k] = S_OFF;
        cnt_d[k]   = '0;
      end else begin
        unique case (state_q[k])
          S_OFF: begin
            cnt_d[k] = deadtime;
            if (dmd_q[k])
              state_d[k] = dt_zero ? S_HI : S_DEAD_HI;
            else
              state_d[k] = dt_zero ? S_LO : S_DEAD_LO;
          end
          S_LO: begin
            if (dmd_q[k]) begin
              cnt_d[k]   = deadtime;
              state_d[k] = dt_zero ? S_HI : S_DEAD_HI;
            end
          end
          S_HI: begin
            if (!dmd_q[k]) begin
              cnt_d[k]   = deadtime;
              state_d[k] = dt_zero ? S_LO : S_DEAD_LO;
            end
          end
          S_DEAD_HI: begin
            if (!dmd_q[k])
              state_d[k] = S_LO;
            else if (cnt_q[k] <= DT_W'(1))
              state_d[k] = S_HI;
            else
              cnt_d[k] = cnt_q[k] - DT_W'(1);
          end
          S_DEAD_LO: begin
            if (dmd_q[k])
              state_d[k] = S_HI;
            else if (cnt_q[k] <= DT_W'(1))
              state_d[k] = S_LO;
            else
              cnt_d[k] = cnt_q[k] - DT_W'(1);
          end
          default: begin
            state_d[k] = S_OFF;
            cnt_d[k]   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      hi[k] = (state_q[k] == S_HI);
      lo[k] = (state_q[k] == S_LO);
    end
    en            = {CHANNELS{en_q}};
    fault_latched = fault_q;
  end

endmodule

// File: tb/tb_ac_motor_pwm_bridge.sv
// Bench for ac_motor_pwm_bridge: three update modes, directed + random.
// Reference model tracks gate side and dead-time countdown per leg.
module tb_ac_motor_pwm_bridge;

  localparam int CH = 3;
  localparam int SW = 12;
  localparam int TW = 17;
  localparam int DW = 8;
  localparam int SCALE = 1 << (TW - SW);
  localparam int MODE [3] = '{1, 2, 0};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ac_motor_pwm_bridge_if #(
    .CHANNELS(CH), .SINE_W(SW), .TRI_W(TW), .DT_W(DW)
  ) bus ();

  logic [CH-1:0] hi_o [3];
  logic [CH-1:0] lo_o [3];
  logic [CH-1:0] en_o [3];
  logic          flt_o [3];

  ac_motor_pwm_bridge #(
    .CHANNELS(CH), .SINE_W(SW), .TRI_W(TW),
    .DT_W(DW), .UPDATE_MODE(1)
  ) u0 (
    .clk(clk), .reset(reset), .enable(bus.enable),
    .tri_peak(bus.tri_peak), .tri_valley(bus.tri_valley),
    .triangle(bus.triangle), .sine(bus.sine),
    .deadtime(bus.deadtime), .fault_in(bus.fault_in),
    .fault_clear(bus.fault_clear),
    .hi(hi_o[0]), .lo(lo_o[0]), .en(en_o[0]),
    .fault_latched(flt_o[0])
  );

  ac_motor_pwm_bridge #(
    .CHANNELS(CH), .SINE_W(SW), .TRI_W(TW),
    .DT_W(DW), .UPDATE_MODE(2)
  ) u1 (
    .clk(clk), .reset(reset), .enable(bus.enable),
    .tri_peak(bus.tri_peak), .tri_valley(bus.tri_valley),
    .triangle(bus.triangle), .sine(bus.sine),
    .deadtime(bus.deadtime), .fault_in(bus.fault_in),
    .fault_clear(bus.fault_clear),
    .hi(hi_o[1]), .lo(lo_o[1]), .en(en_o[1]),
    .fault_latched(flt_o[1])
  );

  ac_motor_pwm_bridge #(
    .CHANNELS(CH), .SINE_W(SW), .TRI_W(TW),
    .DT_W(DW), .UPDATE_MODE(0)
  ) u2 (
    .clk(clk), .reset(reset), .enable(bus.enable),
    .tri_peak(bus.tri_peak), .tri_valley(bus.tri_valley),
    .triangle(bus.triangle), .sine(bus.sine),
    .deadtime(bus.deadtime), .fault_in(bus.fault_in),
    .fault_clear(bus.fault_clear),
    .hi(hi_o[2]), .lo(lo_o[2]), .en(en_o[2]),
    .fault_latched(flt_o[2])
  );

  int total = 0;
  int bad = 0;

  int tri_v;
  int tri_dir;
  bit pk, vl;
  int sine_v [CH];

  // side: 0 off, 1 low conducting, 2 high conducting
  int side_m [3][CH];
  bit dead_m [3][CH];
  int tgt_m  [3][CH];
  int left_m [3][CH];
  int shad_m [3][CH];
  bit d_m    [3][CH];
  bit flt_m, en_m;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.triangle   = TW'(tri_v);
    bus.tri_peak   = pk;
    bus.tri_valley = vl;
    for (int k = 0; k < CH; k++)
      bus.sine[k*SW +: SW] = SW'(sine_v[k]);
  endtask

  task automatic model_step();
    bit fn, kill, ld, nd;
    int want, dt;
    dt = int'(bus.deadtime);
    fn = reset ? 1'b0 : bus.fault_in ? 1'b1 :
         bus.fault_clear ? 1'b0 : flt_m;
    kill = !bus.enable || fn;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < CH; k++) begin
        if (reset) begin
          side_m[i][k] = 0; dead_m[i][k] = 0;
          left_m[i][k] = 0; shad_m[i][k] = 0;
          d_m[i][k] = 0;
        end else begin
          case (MODE[i])
            0:       ld = 1'b1;
            1:       ld = vl;
            default: ld = pk || vl;
          endcase
          nd = (shad_m[i][k] * SCALE) > tri_v;
          want = d_m[i][k] ? 2 : 1;
          if (kill) begin
            side_m[i][k] = 0;
            dead_m[i][k] = 0;
          end else if (dead_m[i][k]) begin
            if (want != tgt_m[i][k]) begin
              side_m[i][k] = want;
              dead_m[i][k] = 0;
            end else if (left_m[i][k] <= 1) begin
              side_m[i][k] = tgt_m[i][k];
              dead_m[i][k] = 0;
            end else begin
              left_m[i][k]--;
            end
          end else if (side_m[i][k] != want) begin
            if (dt == 0) begin
              side_m[i][k] = want;
            end else begin
              dead_m[i][k] = 1;
              tgt_m[i][k]  = want;
              left_m[i][k] = dt;
            end
          end
          if (ld) shad_m[i][k] = sine_v[k];
          d_m[i][k] = nd;
        end
      end
    end
    flt_m = fn;
    en_m  = reset ? 1'b0 : !kill;
  endtask

  task automatic check_all();
    logic [CH-1:0] eh, el;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < CH; k++) begin
        eh[k] = !dead_m[i][k] && side_m[i][k] == 2;
        el[k] = !dead_m[i][k] && side_m[i][k] == 1;
      end
      chk($sformatf("hi%0d", i), 32'(hi_o[i]), 32'(eh));
      chk($sformatf("lo%0d", i), 32'(lo_o[i]), 32'(el));
      chk($sformatf("en%0d", i), 32'(en_o[i]),
          32'({CH{en_m}}));
      chk($sformatf("flt%0d", i), 32'(flt_o[i]), 32'(flt_m));
      chk($sformatf("overlap%0d", i),
          32'(hi_o[i] & lo_o[i]), 32'(0));
    end
  endtask

  task automatic tick();
    apply();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic tri_adv();
    tri_v += tri_dir * 4096;
    if (tri_v >= 61440) tri_dir = -1;
    if (tri_v <= -61440) tri_dir = 1;
    pk = (tri_v == 61440);
    vl = (tri_v == -61440);
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.deadtime = '0;
    bus.fault_in = 1'b0;
    bus.fault_clear = 1'b0;
    tri_v = 0; tri_dir = 1; pk = 0; vl = 0;
    for (int k = 0; k < CH; k++) sine_v[k] = 0;
    flt_m = 0; en_m = 0;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < CH; k++) begin
        side_m[i][k] = 0; dead_m[i][k] = 0;
        tgt_m[i][k] = 0; left_m[i][k] = 0;
        shad_m[i][k] = 0; d_m[i][k] = 0;
      end
    ticks(2);
    chk("rst_hi", 32'(hi_o[2]), 32'(0));
    chk("rst_en", 32'(en_o[2]), 32'(0));

    // settle all legs in LO, deadtime 4
    reset = 1'b0;
    bus.enable = 1'b1;
    bus.deadtime = 8'd4;
    for (int k = 0; k < CH; k++) sine_v[k] = -100;
    ticks(8);
    chk("settle_lo", 32'(lo_o[2]), 32'(3'b111));

    // upward crossing on mode-0 instance
    sine_v[0] = 100;
    ticks(2);
    chk("x_lo_held", 32'(lo_o[2][0]), 32'(1));
    tick();
    chk("x_lo_fall", 32'(lo_o[2][0]), 32'(0));
    for (int j = 0; j < 3; j++) begin
      chk("x_dead_hi", 32'(hi_o[2][0]), 32'(0));
      tick();
    end
    chk("x_dead_hi", 32'(hi_o[2][0]), 32'(0));
    tick();
    chk("x_hi_rise", 32'(hi_o[2][0]), 32'(1));

    // mid-period change ignored until strobes
    ticks(6);
    chk("m1_hold", 32'(lo_o[0][0]), 32'(1));
    chk("m2_hold", 32'(lo_o[1][0]), 32'(1));
    pk = 1; tick(); pk = 0;
    ticks(9);
    chk("m1_peak", 32'(lo_o[0][0]), 32'(1));
    chk("m2_peak", 32'(hi_o[1][0]), 32'(1));
    vl = 1; tick(); vl = 0;
    ticks(9);
    chk("m1_valley", 32'(hi_o[0][0]), 32'(1));

    // zero dead time: direct swap
    bus.deadtime = 8'd0;
    sine_v[0] = -100;
    ticks(2);
    chk("dt0_hi", 32'(hi_o[2][0]), 32'(1));
    tick();
    chk("dt0_swap", 32'({hi_o[2][0], lo_o[2][0]}), 32'(1));
    sine_v[0] = 100;
    ticks(3);
    chk("dt0_back", 32'({hi_o[2][0], lo_o[2][0]}), 32'(2));

    // short demand pulse aborts dead-high
    bus.deadtime = 8'd6;
    sine_v[0] = -100;
    ticks(12);
    sine_v[0] = 100;
    ticks(2);
    sine_v[0] = -100;
    tick();
    chk("ab_dead", 32'(lo_o[2][0]), 32'(0));
    tick();
    chk("ab_hi0", 32'(hi_o[2][0]), 32'(0));
    tick();
    chk("ab_lo", 32'(lo_o[2][0]), 32'(1));
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("ab_hi0", 32'(hi_o[2][0]), 32'(0));
    end

    // fault pulse during HI
    bus.deadtime = 8'd2;
    sine_v[0] = 100;
    ticks(8);
    chk("f_pre", 32'(hi_o[2][0]), 32'(1));
    bus.fault_in = 1'b1; tick(); bus.fault_in = 1'b0;
    chk("f_hi", 32'(hi_o[2]), 32'(0));
    chk("f_lo", 32'(lo_o[2]), 32'(0));
    chk("f_en", 32'(en_o[2]), 32'(0));
    chk("f_lat", 32'(flt_o[2]), 32'(1));
    ticks(3);
    bus.fault_in = 1'b1; bus.fault_clear = 1'b1;
    tick();
    chk("f_both", 32'(flt_o[2]), 32'(1));
    bus.fault_in = 1'b0;
    tick();
    bus.fault_clear = 1'b0;
    chk("f_clr", 32'(flt_o[2]), 32'(0));
    chk("f_clr_en", 32'(en_o[2]), 32'(3'b111));
    tick();
    chk("f_dead", 32'(hi_o[2][0]), 32'(0));
    tick();
    chk("f_rehi", 32'(hi_o[2][0]), 32'(1));

    // reset mid dead-low
    bus.deadtime = 8'd6;
    sine_v[0] = -100;
    ticks(4);
    reset = 1'b1; bus.fault_in = 1'b1; vl = 1;
    tick();
    reset = 1'b0; bus.fault_in = 1'b0; vl = 0;
    chk("r_out", 32'({hi_o[2], lo_o[2], en_o[2]}), 32'(0));
    chk("r_flt", 32'(flt_o[2]), 32'(0));
    ticks(10);

    // randomized run with free-running carrier
    for (int n = 0; n < 800; n++) begin
      tri_adv();
      if ($urandom_range(0, 39) == 0)
        for (int k = 0; k < CH; k++)
          sine_v[k] = int'($urandom_range(0, 4095)) - 2048;
      if ($urandom_range(0, 99) == 0)
        bus.deadtime = DW'($urandom_range(0, 5));
      bus.enable      = ($urandom_range(0, 59) != 0);
      bus.fault_in    = ($urandom_range(0, 199) == 0);
      bus.fault_clear = ($urandom_range(0, 19) == 0);
      reset           = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
